// File: rtl/cook_seq_pkg.sv
// Shared types and helpers for the microwave cooking-cycle controller.
package cook_seq_pkg;

  localparam int PWR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COOK  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Higher encoding wins: each cycle only the most urgent panel event is acted on.
  typedef enum logic [2:0] {
    EV_NONE       = 3'd0,
    EV_START      = 3'd1,
    EV_TIMER_DONE = 3'd2,
    EV_STOP       = 3'd3,
    EV_DOOR_OPEN  = 3'd4,
    EV_CLEAR      = 3'd5
  } event_e;

  function automatic event_e top_event(input logic clearn, input logic door_closed,
                                       input logic stopn, input logic timer_done,
                                       input logic startn);
    if (!clearn)      return EV_CLEAR;
    if (!door_closed) return EV_DOOR_OPEN;
    if (!stopn)       return EV_STOP;
    if (timer_done)   return EV_TIMER_DONE;
    if (!startn)      return EV_START;
    return EV_NONE;
  endfunction

  function automatic logic [PWR_W-1:0] clamp_power(input logic [PWR_W-1:0] level,
                                                   input logic [PWR_W-1:0] max_level);
    return (level > max_level) ? max_level : level;
  endfunction

endpackage

// File: rtl/cook_sequencer_sec_prescaler.sv
// Divides the system clock down to one-second ticks; counts only while enabled.
module sec_prescaler #(
  parameter int CLK_PER_SEC = 100
) (
  input  logic clock,
  input  logic resetn,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = $clog2(CLK_PER_SEC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap   = (cnt_q == CW'(CLK_PER_SEC - 1));
  assign tick_o = en_i & wrap;

  // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same old values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cook_sequencer.sv
// Microwave cooking-cycle FSM: timer gating, magnetron duty cycling, door interlock, beep.
// Define COOK_SEQ_BEEP_EN to enable the timed completion beep; otherwise DONE lasts one cycle.
module cook_sequencer
  import cook_seq_pkg::*;
#(
  parameter int CLK_PER_SEC = 100,
  parameter int DUTY_WINDOW = 10,
  parameter int BEEP_SECS   = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             startn,
  input  logic             stopn,
  input  logic             clearn,
  input  logic             door_closed,
  input  logic [PWR_W-1:0] power_level,
  input  logic             timer_done,
  output logic             timer_run,
  output logic             mag_on,
  output logic             beep,
  output logic             sec_tick,
  output logic [1:0]       state
);

  state_e           state_q, state_d;
  event_e           ev;
  logic [PWR_W-1:0] power_q, power_d, window_q, window_d;
  logic             tick, cook_tick, presc_en, presc_clr, beep_done;
  logic             fresh_start, resume, entering_done;
  logic             timer_run_q, timer_run_d, mag_on_q, mag_on_d;
  logic             sec_tick_q, sec_tick_d, beep_q, beep_d;

  // A paused cook may resume with the timer already expired; it then finishes via COOK.
  assign ev = top_event(clearn, door_closed, stopn,
                        timer_done && (state_q != ST_PAUSE), startn);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (ev == EV_START) state_d = ST_COOK;
      ST_COOK: begin
        case (ev)
          EV_CLEAR:              state_d = ST_IDLE;
          EV_DOOR_OPEN, EV_STOP: state_d = ST_PAUSE;
          EV_TIMER_DONE:         state_d = ST_DONE;
          default:               state_d = ST_COOK;
        endcase
      end
      ST_PAUSE: begin
        if (ev == EV_CLEAR)      state_d = ST_IDLE;
        else if (ev == EV_START) state_d = ST_COOK;
      end
      ST_DONE: begin
        if (ev inside {EV_CLEAR, EV_DOOR_OPEN, EV_STOP} || beep_done) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  assign fresh_start   = (state_q == ST_IDLE)  && (state_d == ST_COOK);
  assign resume        = (state_q == ST_PAUSE) && (state_d == ST_COOK);
  assign entering_done = (state_q != ST_DONE)  && (state_d == ST_DONE);
  assign presc_clr     = fresh_start || entering_done;
  assign cook_tick     = tick && (state_q == ST_COOK);

  sec_prescaler #(.CLK_PER_SEC(CLK_PER_SEC)) u_prescaler (
    .clock  (clock),
    .resetn (resetn),
    .en_i   (presc_en),
    .clr_i  (presc_clr),
    .tick_o (tick)
  );

`ifdef COOK_SEQ_BEEP_EN
  localparam int BW = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;

  logic [BW-1:0] beep_cnt_q, beep_cnt_d;

  assign presc_en  = (state_q == ST_COOK) || (state_q == ST_DONE);
  assign beep_done = tick && (state_q == ST_DONE) && (beep_cnt_q == BW'(BEEP_SECS - 1));

  always_comb begin
    beep_cnt_d = beep_cnt_q;
    if (presc_clr)                         beep_cnt_d = '0;
    else if (tick && state_q == ST_DONE)   beep_cnt_d = beep_cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) beep_cnt_q <= '0;
    else         beep_cnt_q <= beep_cnt_d;
  end
`else
  assign presc_en  = (state_q == ST_COOK);
  assign beep_done = 1'b1;
`endif

  always_comb begin
    power_d  = power_q;
    window_d = window_q;
    if (fresh_start || resume) power_d = clamp_power(power_level, PWR_W'(DUTY_WINDOW));
    if (fresh_start)    window_d = '0;
    else if (cook_tick) window_d = (window_q == PWR_W'(DUTY_WINDOW - 1)) ? '0 : window_q + 1'b1;
  end

  // Outputs are computed from next-state values so they change on the same edge as state.
  always_comb begin
    timer_run_d = (state_d == ST_COOK);
    mag_on_d    = (state_d == ST_COOK) && (window_d < power_d);
    sec_tick_d  = cook_tick;
`ifdef COOK_SEQ_BEEP_EN
    beep_d      = (state_d == ST_DONE);
`else
    beep_d      = 1'b0;
`endif
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      power_q     <= '0;
      window_q    <= '0;
      timer_run_q <= 1'b0;
      mag_on_q    <= 1'b0;
      sec_tick_q  <= 1'b0;
      beep_q      <= 1'b0;
    end else begin
      power_q     <= power_d;
      window_q    <= window_d;
      timer_run_q <= timer_run_d;
      mag_on_q    <= mag_on_d;
      sec_tick_q  <= sec_tick_d;
      beep_q      <= beep_d;
    end
  end

  assign timer_run = timer_run_q;
  assign mag_on    = mag_on_q;
  assign sec_tick  = sec_tick_q;
  assign beep      = beep_q;
  assign state     = state_q;

endmodule

// File: tb/tb_cook_sequencer.sv
// Directed self-checking bench for cook_sequencer (CLK_PER_SEC=4, DUTY_WINDOW=10, BEEP_SECS=3).
module tb_cook_sequencer;

  logic       clock, resetn, startn, stopn, clearn, door_closed, timer_done;
  logic [3:0] power_level;
  logic       timer_run, mag_on, beep, sec_tick;
  logic [1:0] state;

  int tests  = 0;
  int failed = 0;

`ifdef COOK_SEQ_BEEP_EN
  localparam logic BEEP_ON = 1'b1;
`else
  localparam logic BEEP_ON = 1'b0;
`endif

  cook_sequencer #(.CLK_PER_SEC(4), .DUTY_WINDOW(10), .BEEP_SECS(3)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .startn      (startn),
    .stopn       (stopn),
    .clearn      (clearn),
    .door_closed (door_closed),
    .power_level (power_level),
    .timer_done  (timer_done),
    .timer_run   (timer_run),
    .mag_on      (mag_on),
    .beep        (beep),
    .sec_tick    (sec_tick),
    .state       (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {state, timer_run, mag_on, sec_tick, beep}
  function automatic logic [5:0] obs();
    return {state, timer_run, mag_on, sec_tick, beep};
  endfunction

  function automatic logic [5:0] ex(input logic [1:0] st, input logic tr, input logic mo,
                                    input logic tk, input logic bp);
    return {st, tr, mo, tk, bp};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_cook(input logic [3:0] p);
    power_level = p;
    startn = 1'b0;
    step();
    startn = 1'b1;
  endtask

  task automatic do_clear();
    clearn = 1'b0;
    step();
    clearn = 1'b1;
  endtask

  task automatic test_reset();
    logic [5:0] e;
    resetn = 1'b0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    door_closed = 1'b1; timer_done = 1'b0; power_level = 4'd0;
    #12;
    e = ex(2'd0, 0, 0, 0, 0);
    tests++;
    if (obs() !== e) begin failed++; $display("FAIL reset_hold: got %b want %b", obs(), e); end
    resetn = 1'b1;
    step();
    tests++;
    if (obs() !== e) begin failed++; $display("FAIL reset_release: got %b want %b", obs(), e); end
  endtask

  task automatic test_power5();
    logic [5:0] e;
    int w;
    start_cook(4'd5);
    e = ex(2'd1, 1, 1, 0, 0);
    tests++;
    if (obs() !== e) begin failed++; $display("FAIL p5_entry: got %b want %b", obs(), e); end
    for (int k = 1; k <= 44; k++) begin
      step();
      w = (k / 4) % 10;
      e = ex(2'd1, 1, (w < 5), (k % 4 == 0), 0);
      tests++;
      if (obs() !== e) begin failed++; $display("FAIL p5_cycle%0d: got %b want %b", k, obs(), e); end
    end
    do_clear();
    e = ex(2'd0, 0, 0, 0, 0);
    tests++;
    if (obs() !== e) begin failed++; $display("FAIL p5_clear: got %b want %b", obs(), e); end
  endtask

  task automatic test_clamp();
    start_cook(4'd15);
    for (int k = 0; k < 44; k++) begin
      tests++;
      if ({timer_run, mag_on} !== 2'b11) begin
        failed++; $display("FAIL p15_cycle%0d: got tr/mag %b want 11", k, {timer_run, mag_on});
      end
      step();
    end
    do_clear();
    start_cook(4'd0);
    for (int k = 0; k < 44; k++) begin
      tests++;
      if ({timer_run, mag_on} !== 2'b10) begin
        failed++; $display("FAIL p0_cycle%0d: got tr/mag %b want 10", k, {timer_run, mag_on});
      end
      step();
    end
    do_clear();
  endtask

  // Ends in COOK with window=5, power=5.
  task automatic test_door();
    logic [5:0] e;
    start_cook(4'd2);
    for (int k = 0; k < 13; k++) step();
    e = ex(2'd1, 1, 0, 0, 0);
    tests++;
    if (obs() !== e) begin failed++; $display("FAIL door_pre_w3: got %b want %b", obs(), e); end
    door_closed = 1'b0;
    step();
    e = ex(2'd2, 0, 0, 0, 0);
    tests++;
    if (obs() !== e) begin failed++; $display("FAIL door_open_pause: got %b want %b", obs(), e); end
    step(); step(); step();
    tests++;
    if (obs() !== e) begin failed++; $display("FAIL door_pause_hold: got %b want %b", obs(), e); end
    door_closed = 1'b1;
    start_cook(4'd5);
    e = ex(2'd1, 1, 1, 0, 0);
    tests++;
    if (obs() !== e) begin failed++; $display("FAIL door_resume: got %b want %b", obs(), e); end
    step();
    tests++;
    if (obs() !== e) begin failed++; $display("FAIL door_resume_r1: got %b want %b", obs(), e); end
    step();
    e = ex(2'd1, 1, 1, 1, 0);
    tests++;
    if (obs() !== e) begin failed++; $display("FAIL door_tick_w4: got %b want %b", obs(), e); end
    step(); step(); step();
    e = ex(2'd1, 1, 1, 0, 0);
    tests++;
    if (obs() !== e) begin failed++; $display("FAIL door_r5_w4: got %b want %b", obs(), e); end
    step();
    e = ex(2'd1, 1, 0, 1, 0);
    tests++;
    if (obs() !== e) begin failed++; $display("FAIL door_tick_w5: got %b want %b", obs(), e); end
  endtask

  task automatic test_done();
    logic [5:0] e;
    timer_done = 1'b1;
    step();
    e = ex(2'd3, 0, 0, 0, BEEP_ON);
    tests++;
    if (obs() !== e) begin failed++; $display("FAIL done_entry: got %b want %b", obs(), e); end
    if (BEEP_ON) begin
      for (int k = 1; k <= 11; k++) begin
        step();
        tests++;
        if (obs() !== e) begin failed++; $display("FAIL done_beep%0d: got %b want %b", k, obs(), e); end
      end
    end
    step();
    e = ex(2'd0, 0, 0, 0, 0);
    tests++;
    if (obs() !== e) begin failed++; $display("FAIL done_to_idle: got %b want %b", obs(), e); end
  endtask

  task automatic test_start_blocked();
    logic [5:0] e;
    e = ex(2'd0, 0, 0, 0, 0);
    timer_done = 1'b1; startn = 1'b0;
    step();
    tests++;
    if (obs() !== e) begin failed++; $display("FAIL start_timer_done: got %b want %b", obs(), e); end
    timer_done = 1'b0; door_closed = 1'b0;
    step();
    tests++;
    if (obs() !== e) begin failed++; $display("FAIL start_door_open: got %b want %b", obs(), e); end
    door_closed = 1'b1; stopn = 1'b0;
    step();
    tests++;
    if (obs() !== e) begin failed++; $display("FAIL start_with_stop: got %b want %b", obs(), e); end
    stopn = 1'b1; startn = 1'b1;
  endtask

  task automatic test_stop_and_done();
    logic [5:0] e;
    start_cook(4'd5);
    step();
    stopn = 1'b0; timer_done = 1'b1;
    step();
    e = ex(2'd2, 0, 0, 0, 0);
    tests++;
    if (obs() !== e) begin failed++; $display("FAIL stop_beats_done: got %b want %b", obs(), e); end
    stopn = 1'b1;
    start_cook(4'd5);
    e = ex(2'd1, 1, 1, 0, 0);
    tests++;
    if (obs() !== e) begin failed++; $display("FAIL stop_resume: got %b want %b", obs(), e); end
    step();
    e = ex(2'd3, 0, 0, 0, BEEP_ON);
    tests++;
    if (obs() !== e) begin failed++; $display("FAIL stop_then_done: got %b want %b", obs(), e); end
    timer_done = 1'b0;
    do_clear();
    e = ex(2'd0, 0, 0, 0, 0);
    tests++;
    if (obs() !== e) begin failed++; $display("FAIL stop_clear: got %b want %b", obs(), e); end
  endtask

  task automatic test_clear_in_pause();
    logic [5:0] e;
    start_cook(4'd5);
    door_closed = 1'b0;
    step();
    e = ex(2'd2, 0, 0, 0, 0);
    tests++;
    if (obs() !== e) begin failed++; $display("FAIL clr_pause_entry: got %b want %b", obs(), e); end
    door_closed = 1'b1; clearn = 1'b0; startn = 1'b0;
    step();
    clearn = 1'b1; startn = 1'b1;
    e = ex(2'd0, 0, 0, 0, 0);
    tests++;
    if (obs() !== e) begin failed++; $display("FAIL clr_beats_start: got %b want %b", obs(), e); end
  endtask

  task automatic test_async_reset();
    logic [5:0] e;
    start_cook(4'd5);
    step(); step();
    #2 resetn = 1'b0;
    #1;
    e = ex(2'd0, 0, 0, 0, 0);
    tests++;
    if (obs() !== e) begin failed++; $display("FAIL async_reset: got %b want %b", obs(), e); end
    #3 resetn = 1'b1;
    step();
    tests++;
    if (obs() !== e) begin failed++; $display("FAIL reset_stays_idle: got %b want %b", obs(), e); end
    start_cook(4'd5);
    step(); step(); step(); step();
    e = ex(2'd1, 1, 1, 1, 0);
    tests++;
    if (obs() !== e) begin failed++; $display("FAIL post_reset_tick: got %b want %b", obs(), e); end
    do_clear();
  endtask

  initial begin
    test_reset();
    test_power5();
    test_clamp();
    test_door();
    test_done();
    test_start_blocked();
    test_stop_and_done();
    test_clear_in_pause();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/cook_sequencer.md
# cook_sequencer

Cooking-cycle controller for the microwave datapath. Sits between the debounced front-panel buttons, door switch and power-level selector on one side and the timer and magnetron drive on the other. Gates timer countdown, duty-cycles the magnetron to implement power levels 0–10, handles pause/resume and door interlock, and sounds a completion beep.

## Interface
Parameters:
- CLK_PER_SEC, 100, clock cycles per one-second tick (≥2)
- DUTY_WINDOW, 10, seconds per magnetron duty window; also the maximum power level
- BEEP_SECS, 3, seconds the beep stays on in DONE

Ports:
- clock  in  1  system clock; all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- startn  in  1  start/resume, active-low, synchronous, level-sampled
- stopn  in  1  pause, active-low, synchronous
- clearn  in  1  cancel, active-low, synchronous (functional clear, not reset)
- door_closed  in  1  1 = door closed
- power_level  in  4  requested power 0..10; values >DUTY_WINDOW clamp to DUTY_WINDOW
- timer_done  in  1  timer count is zero
- timer_run  out  1  enables timer countdown
- mag_on  out  1  magnetron drive
- beep  out  1  buzzer drive
- sec_tick  out  1  one-cycle pulse per elapsed cooking second
- state  out  2  current state code (IDLE=0, COOK=1, PAUSE=2, DONE=3)

## Operation
- FSM states: IDLE, COOK, PAUSE, DONE. Event priority each cycle: resetn > clearn > door open > stopn > timer_done > startn.
- IDLE: startn=0 & door_closed & !timer_done → COOK; latch clamped power_level; clear prescaler, window and beep counters. startn while timer_done=1 or door open → stay IDLE.
- COOK: clearn=0 → IDLE; door_closed=0 or stopn=0 → PAUSE; timer_done=1 → DONE.
- PAUSE: clearn=0 → IDLE; startn=0 & door_closed → COOK; re-latch power_level; prescaler and window counters resume from frozen values.
- DONE: beep=1; beep counter advances on internal second ticks; after BEEP_SECS seconds → IDLE. clearn=0, stopn=0 or door open → IDLE immediately.
- Prescaler: counts 0..CLK_PER_SEC-1 only in COOK (and DONE for beep timing); sec_tick=1 on the cycle it wraps, COOK only.
- Window counter: 0..DUTY_WINDOW-1, increments on sec_tick, wraps to 0.
- mag_on = (state==COOK) & (window < power_latched). Power 0 → timer runs, magnetron never on; power 10 → continuously on.
- timer_run = (state==COOK). beep = (state==DONE).

## Timing
- Reset: state=IDLE, all outputs 0, all counters 0, power_latched=0.
- Outputs are registered, updated on the same edge as state; 1-cycle latency from sampled input to output.
- First sec_tick CLK_PER_SEC cycles after COOK entry from IDLE.
- Door opening drops mag_on and timer_run on the next edge; no combinational path from door_closed to mag_on.
- timer_done and stopn in the same cycle → PAUSE (stopn wins); cooking resumes and reaches DONE on the next cycle.
- resetn mid-operation clears everything asynchronously; release is synchronous.

## Configuration
- COOK_SEQ_BEEP_EN defined: DONE behaves as above.
- Undefined: beep tied 0, beep counter removed, DONE lasts exactly one cycle and then → IDLE.

## Structure
- Package cook_seq_pkg: state enum and encodings, event-priority constants, power clamp function.
- One sub-module: sec_prescaler (CLK_PER_SEC counter, enable/clear, emits tick).

## Test plan
(CLK_PER_SEC=4, DUTY_WINDOW=10, BEEP_SECS=3)
- power 5, start in IDLE → timer_run=1 steady; mag_on high 20 cycles, low 20, repeating; sec_tick every 4 cycles.
- power 15 → clamped to 10, mag_on continuously high; power 0 → mag_on never high, timer_run=1.
- door opened at window=3 → PAUSE next edge, mag_on=timer_run=0; close door and start with power 5 → mag_on=1, window resumes at 3.
- timer_done in COOK → DONE, beep=1 for 12 cycles, then IDLE; undefined macro → DONE lasts 1 cycle, beep never 1.
- start while timer_done=1 → stays IDLE; clearn and startn together in PAUSE → IDLE.
- resetn low mid-COOK → all outputs 0 immediately, state=IDLE.
